ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  Complements the PS/2 receive path; shares the inout ps2_clock/ps2_data pins via open-drain enables.
//  Top level drives: ps2_clock = ps2_clk_oe ? 1'b0 : 1'bz; ps2_data = ps2_data_oe ? 1'b0 : 1'bz.
//  The receive path must ignore traffic while tx_busy=1.
// PARAMETERS
//  INHIBIT_CYCLES  5000     clocks ps2_clock is held low before the request (100 us at 50 MHz)
//  TIMEOUT_CYCLES  750000   max clocks from release of ps2_clock to ACK (15 ms at 50 MHz)
// PORTS
//  clock        in   1  system clock (CLOCK_50 domain)
//  reset        in   1  asynchronous, active-high reset
//  tx_data      in   8  command byte; sampled on accept
//  tx_valid     in   1  request; accepted when tx_valid & tx_ready
//  tx_ready     out  1  1 in IDLE only
//  tx_busy      out  1  ~tx_ready
//  tx_done      out  1  1-cycle pulse: frame sent and device ACK seen
//  tx_error     out  1  1-cycle pulse: no ACK or timeout
//  ps2_clk_in   in   1  raw ps2_clock pin level (asynchronous)
//  ps2_data_in  in   1  raw ps2_data pin level (asynchronous)
//  ps2_clk_oe   out  1  1 = pull ps2_clock low
//  ps2_data_oe  out  1  1 = pull ps2_data low
// BEHAVIOUR
//  Reset (async): state IDLE; tx_ready=1; tx_done=tx_error=0; both oe=0 immediately; counters cleared.
//  Inputs pass through 2-flop synchronizers; fall = sync_clk_prev & ~sync_clk (1 cycle after the 2-flop delay).
//  Accept: latch tx_data into shift reg, parity = ~^tx_data (odd). Requests while busy are ignored, not queued.
//  States:
//   IDLE    oe=00. On accept -> INHIBIT, cnt=0.
//   INHIBIT clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES clocks -> REQ.
//   REQ     clk_oe=1, data_oe=1 (start bit) for 1 clock -> SEND; bit_idx=0, timeout cnt=0.
//   SEND    clk_oe=0. data_oe = ~bit (drive low for 0, release for 1). On each fall: bit_idx++ and present
//           the next bit: falls 1-8 -> d0..d7 (LSB first), fall 9 -> parity, fall 10 -> stop (data_oe=0).
//           On fall 11: sample sync_data; 0 -> WAITREL, 1 -> ERR.
//   WAITREL both oe=0; wait until sync_clk=1 and sync_data=1 -> DONE.
//   DONE    1 cycle -> IDLE; tx_done=1 in the first IDLE cycle (registered).
//   ERR     both oe=0, 1 cycle -> IDLE; tx_error=1 in the first IDLE cycle.
//  Timeout: counter runs in SEND and WAITREL; reaching TIMEOUT_CYCLES -> ERR (both lines released).
//  tx_ready=1 in the same cycle as tx_done/tx_error, so back-to-back accepts are legal.
//  tx_done and tx_error are never both 1; each is high for exactly one cycle per frame.
//  Reset mid-frame: lines released asynchronously; no done/error pulse; next frame restarts at INHIBIT.
//  Falls seen in IDLE, INHIBIT or REQ are ignored (e.g. the receive path's own traffic).
//  Counter widths: $clog2(param+1); bit_idx is 4 bits and saturates at 11.
// TESTING (INHIBIT_CYCLES=8, TIMEOUT_CYCLES=2000, device model clocks with a 40-cycle period)
//  1. Send 0xED -> clk_oe high for exactly 8 cycles, then 1 REQ cycle with both oe; device samples 0,1,0,1,1,0,1,1,1,
//     parity 1, stop 1; device ACKs -> one tx_done pulse, tx_error stays 0.
//  2. Parity: 0x00 -> parity 1; 0x01 -> parity 0; 0xFF -> parity 1; device-checked on each.
//  3. Device leaves data high on the 11th clock -> tx_error pulse, tx_done 0, both oe 0, tx_ready 1.
//  4. Device never clocks -> tx_error exactly 2000 cycles after SEND is entered; lines released.
//  5. Reset asserted at bit 4 -> both oe 0 in the same cycle, no pulses; a following 0xFF frame completes correctly.
//  6. tx_valid pulsed while busy (0xAA) -> ignored; tx_valid held with 0xF4 during the tx_done cycle -> accepted,
//     INHIBIT starts on the next clock.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: start bit, 8 data bits LSB first, odd parity, stop, then device ACK.
// The pin enables are open-drain style: 1 pulls the line low, 0 releases it.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_REQ     = 3'd2,
        S_SEND    = 3'd3,
        S_WAITREL = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2;
    logic [7:0]    r_data;
    logic          r_parity;
    logic [IW-1:0] r_inh_cnt, w_inh_cnt_nxt;
    logic [TW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
    logic [3:0]    r_bit_idx, w_bit_idx_nxt;
    logic          r_ready, r_done, r_error, r_clk_oe, r_data_oe;
    logic          w_fall, w_accept, w_clk_oe_nxt, w_data_oe_nxt;
    logic [10:0]   w_frame;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    assign w_fall   = r_clk_prev & ~r_clk_s2;
    assign w_accept = tx_valid & r_ready;
    assign w_frame  = {1'b1, r_parity, r_data, 1'b0};

    // Two-flop synchronizers for the raw pins plus the delayed clock used for fall detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data_in;
            r_dat_s2   <= r_dat_s1;
        end
    end

    // Next-state, counters and bit index; the timeout moves to ERR after TIMEOUT_CYCLES cycles in SEND/WAITREL.
    always_comb begin
        w_state_nxt   = r_state;
        w_inh_cnt_nxt = r_inh_cnt;
        w_tmo_cnt_nxt = r_tmo_cnt;
        w_bit_idx_nxt = r_bit_idx;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = S_INHIBIT;
                    w_inh_cnt_nxt = '0;
                end else begin
                    w_state_nxt   = S_IDLE;
                end
            end
            S_INHIBIT: begin
                if (r_inh_cnt == INH_LAST) begin
                    w_state_nxt   = S_REQ;
                end else begin
                    w_inh_cnt_nxt = r_inh_cnt + 1'b1;
                end
            end
            S_REQ: begin
                w_state_nxt   = S_SEND;
                w_bit_idx_nxt = 4'd0;
                w_tmo_cnt_nxt = '0;
            end
            S_SEND: begin
                w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nxt = S_ERR;
                end else if (w_fall) begin
                    if (r_bit_idx != 4'd11) begin
                        w_bit_idx_nxt = r_bit_idx + 4'd1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx;
                    end
                    // Fall 11 is the ACK slot: the device must be holding data low.
                    if (r_bit_idx == 4'd10) begin
                        w_state_nxt = r_dat_s2 ? S_ERR : S_WAITREL;
                    end else begin
                        w_state_nxt = S_SEND;
                    end
                end else begin
                    w_state_nxt = S_SEND;
                end
            end
            S_WAITREL: begin
                w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nxt = S_ERR;
                end else if (r_clk_s2 && r_dat_s2) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_WAITREL;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pin enables for the upcoming state, so the registered outputs line up with the state register.
    always_comb begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        case (w_state_nxt)
            S_INHIBIT: w_clk_oe_nxt = 1'b1;
            S_REQ: begin
                w_clk_oe_nxt  = 1'b1;
                w_data_oe_nxt = 1'b1;
            end
            S_SEND: begin
                if (w_bit_idx_nxt <= 4'd10) begin
                    w_data_oe_nxt = ~w_frame[w_bit_idx_nxt];
                end else begin
                    w_data_oe_nxt = 1'b0;
                end
            end
            default: begin
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
            end
        endcase
    end

    // State, counters, latched command byte and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_inh_cnt <= '0;
            r_tmo_cnt <= '0;
            r_bit_idx <= 4'd0;
            r_data    <= 8'h00;
            r_parity  <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_inh_cnt <= w_inh_cnt_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            if (w_accept) begin
                r_data   <= tx_data;
                r_parity <= odd_parity(tx_data);
            end else begin
                r_data   <= r_data;
                r_parity <= r_parity;
            end
            r_ready   <= (w_state_nxt == S_IDLE);
            r_done    <= (r_state == S_DONE);
            r_error   <= (r_state == S_ERR);
            r_clk_oe  <= w_clk_oe_nxt;
            r_data_oe <= w_data_oe_nxt;
        end
    end

    assign tx_ready    = r_ready;
    assign tx_busy     = ~r_ready;
    assign tx_done     = r_done;
    assign tx_error    = r_error;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks the frame in, a scoreboard queue holds the
// expected outcome of each accepted command and a monitor checks every tx_done/tx_error pulse against it.
module tb_ps2_host_tx;
    localparam int INH = 8;
    localparam int TMO = 2000;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk, dev_data;
    logic       w_ps2_clk, w_ps2_dat;

    typedef struct packed {
        logic       err;
        logic       par;
        logic [7:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          dev_mode = 0;
    logic        dev_abort = 1'b0;
    logic        dev_active = 1'b0;
    int          dev_falls = 0;
    logic [10:0] dev_bits = '0;

    assign w_ps2_clk = ~ps2_clk_oe & dev_clk;
    assign w_ps2_dat = ~ps2_data_oe & dev_data;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
        .ps2_clk_in(w_ps2_clk), .ps2_data_in(w_ps2_dat),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic dev_wait(input int n);
        for (int i = 0; i < n; i++) begin
            if (dev_abort) return;
            @(negedge clock);
        end
    endtask

    // Device side: 40-cycle clock period, samples on the rising edge, ACK unless dev_mode==1.
    task automatic run_frame();
        dev_active  = 1'b1;
        dev_falls   = 0;
        dev_bits    = '0;
        dev_bits[0] = w_ps2_dat;
        for (int k = 1; k <= 10; k++) begin
            dev_wait(20);
            if (dev_abort) break;
            dev_clk   = 1'b0;
            dev_falls = k;
            dev_wait(20);
            if (dev_abort) break;
            dev_clk     = 1'b1;
            dev_bits[k] = w_ps2_dat;
        end
        if (!dev_abort) begin
            dev_wait(10);
            if (dev_mode == 0) dev_data = 1'b0;
            dev_wait(10);
            dev_clk   = 1'b0;
            dev_falls = 11;
            dev_wait(20);
            dev_clk = 1'b1;
            dev_wait(5);
        end
        dev_clk    = 1'b1;
        dev_data   = 1'b1;
        dev_active = 1'b0;
    endtask

    initial begin
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        forever begin
            @(negedge clock);
            if (!reset && !dev_abort && !ps2_clk_oe && ps2_data_oe && dev_mode != 2) run_frame();
        end
    end

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (tx_done || tx_error) begin
                chk("done_error_exclusive", 32'(tx_done & tx_error), 32'd0);
                chk("ready_with_pulse", 32'(tx_ready), 32'd1);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: done=%0b error=%0b with no frame outstanding", tx_done, tx_error);
                end else begin
                    e = sb_q.pop_front();
                    chk("pulse_is_error", 32'(tx_error), 32'(e.err));
                    if (!e.err) begin
                        chk("dev_start_bit", 32'(dev_bits[0]), 32'd0);
                        chk("dev_data_byte", 32'(dev_bits[8:1]), 32'(e.data));
                        chk("dev_parity_bit", 32'(dev_bits[9]), 32'(e.par));
                        chk("dev_stop_bit", 32'(dev_bits[10]), 32'd1);
                    end else begin
                        chk("error_lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
                    end
                end
            end
        end
    end

    task automatic accept(input logic [7:0] d, input logic par, input logic err, input logic push);
        exp_t e;
        @(negedge clock);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clock);
        #1;
        tx_valid = 1'b0;
        chk("accepted_busy", 32'(tx_busy), 32'd1);
        if (push) begin
            e.err  = err;
            e.par  = par;
            e.data = d;
            sb_q.push_back(e);
        end
    endtask

    task automatic measure_inh(output int n_inh, output int n_req);
        n_inh = 0;
        n_req = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (ps2_clk_oe && !ps2_data_oe) n_inh++;
            else break;
        end
        for (int i = 0; i < 100; i++) begin
            if (ps2_clk_oe && ps2_data_oe) begin
                n_req++;
                @(negedge clock);
            end else begin
                break;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 4000; i++) begin
            if (tx_ready) return;
            @(negedge clock);
        end
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for tx_ready", name);
    endtask

    task automatic wait_dev_idle();
        for (int i = 0; i < 200; i++) begin
            if (!dev_active) return;
            @(negedge clock);
        end
        checks++;
        errors++;
        $display("FAIL device_idle: device model still active after 200 cycles");
    endtask

    task automatic finish_frame(input string name);
        wait_idle(name);
        @(negedge clock);
        chk(name, 32'(sb_q.size()), 32'd0);
        wait_dev_idle();
    endtask

    logic [7:0] vec_data [3] = '{8'h00, 8'h01, 8'hFF};
    logic       vec_par  [3] = '{1'b1, 1'b0, 1'b1};

    initial begin
        int   ni, nr, kerr;
        logic [1:0] oe_1999, oe_2000;
        logic got_done;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clock);
        chk("reset_ready", 32'(tx_ready), 32'd1);
        chk("reset_busy", 32'(tx_busy), 32'd0);
        chk("reset_pulses", 32'({tx_done, tx_error}), 32'd0);
        chk("reset_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        reset = 1'b0;

        // 0xED with inhibit/request timing
        accept(8'hED, 1'b1, 1'b0, 1'b1);
        measure_inh(ni, nr);
        chk("inhibit_cycles", 32'(ni), 32'd8);
        chk("req_cycles", 32'(nr), 32'd1);
        chk("send_start_bit_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
        finish_frame("ed_frame_complete");

        foreach (vec_data[i]) begin
            accept(vec_data[i], vec_par[i], 1'b0, 1'b1);
            finish_frame("parity_frame_complete");
        end

        // No ACK on the 11th clock
        dev_mode = 1;
        accept(8'h12, 1'b1, 1'b1, 1'b1);
        finish_frame("noack_frame_complete");
        chk("noack_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("noack_ready", 32'(tx_ready), 32'd1);
        dev_mode = 0;

        // Silent device: lines released TMO cycles into SEND, error pulse the cycle after
        dev_mode = 2;
        accept(8'h34, 1'b0, 1'b1, 1'b1);
        measure_inh(ni, nr);
        kerr    = 0;
        oe_1999 = 2'b11;
        oe_2000 = 2'b11;
        for (int k = 1; k <= 2100; k++) begin
            @(negedge clock);
            if (k == 1999) oe_1999 = {ps2_clk_oe, ps2_data_oe};
            if (k == 2000) oe_2000 = {ps2_clk_oe, ps2_data_oe};
            if (tx_error) begin
                kerr = k;
                break;
            end
        end
        chk("timeout_oe_before", 32'(oe_1999), 32'b01);
        chk("timeout_oe_released", 32'(oe_2000), 32'b00);
        chk("timeout_error_cycle", 32'(kerr), 32'd2001);
        @(negedge clock);
        chk("timeout_frame_complete", 32'(sb_q.size()), 32'd0);
        dev_mode = 0;

        // Reset during bit 4, then a clean 0xFF frame
        accept(8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            if (dev_falls == 4) break;
            @(negedge clock);
        end
        repeat (10) @(negedge clock);
        chk("midframe_data_oe", 32'(ps2_data_oe), 32'd1);
        @(posedge clock);
        #2;
        dev_abort = 1'b1;
        reset     = 1'b1;
        #1;
        chk("reset_async_release", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("reset_no_pulse", 32'({tx_done, tx_error}), 32'd0);
        end
        wait_dev_idle();
        dev_abort = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        accept(8'hFF, 1'b1, 1'b0, 1'b1);
        measure_inh(ni, nr);
        chk("after_reset_inhibit", 32'(ni), 32'd8);
        finish_frame("after_reset_frame_complete");

        // Requests while busy are dropped; a request held through tx_done is taken at once
        accept(8'h55, 1'b1, 1'b0, 1'b1);
        @(negedge clock);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (dev_falls == 3) break;
            @(negedge clock);
        end
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        got_done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            if (tx_done) begin
                got_done = 1'b1;
                break;
            end
        end
        chk("b2b_done_seen", 32'(got_done), 32'd1);
        chk("b2b_ready_at_done", 32'(tx_ready), 32'd1);
        begin
            exp_t e;
            e.err  = 1'b0;
            e.par  = 1'b0;
            e.data = 8'hF4;
            sb_q.push_back(e);
        end
        @(posedge clock);
        #1;
        tx_valid = 1'b0;
        chk("b2b_inhibit_next_clock", 32'({ps2_clk_oe, ps2_data_oe}), 32'b10);
        chk("b2b_busy", 32'(tx_busy), 32'd1);
        finish_frame("b2b_frame_complete");

        chk("final_scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
